// File: rtl/rect_fill_engine.sv
// rect_fill_engine: rectangle-fill pixel-write generator for the frame buffer.
// Accepts one fill command via cmd_valid/cmd_ready and emits one registered
// frame-buffer write per clock, in raster order, until the rectangle is covered.
// Optional feature: define RECT_FILL_CLIP_EN to clamp the rectangle to the
// visible H_RES x V_RES area. A command lying fully off-screen is then accepted
// with no writes.
module rect_fill_engine #(
    parameter int unsigned H_RES = 320,
    parameter int unsigned V_RES = 240
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x0,
    input  logic [9:0] cmd_y0,
    input  logic [9:0] cmd_x1,
    input  logic [9:0] cmd_y1,
    input  logic [3:0] cmd_color,
    output logic [9:0] gpu_x,
    output logic [9:0] gpu_y,
    output logic [3:0] gpu_data,
    output logic       gpu_we,
    output logic       busy,
    output logic       done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

`ifdef RECT_FILL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    // Last visible column/row; only consulted when clipping is enabled.
    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    logic [0:0] state_q, state_d;
    logic [9:0] xmin_q, xmin_d;
    logic [9:0] xmax_q, xmax_d;
    logic [9:0] ymax_q, ymax_d;
    logic [9:0] gpu_x_q, gpu_x_d;
    logic [9:0] gpu_y_q, gpu_y_d;
    logic [3:0] gpu_data_q, gpu_data_d;
    logic       gpu_we_q, gpu_we_d;
    logic       done_q, done_d;

    logic       accept;
    logic [9:0] norm_xmin, norm_xmax, norm_ymin, norm_ymax;
    logic       off_screen;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_FILL);
    assign accept    = cmd_valid && cmd_ready;

    assign gpu_x    = gpu_x_q;
    assign gpu_y    = gpu_y_q;
    assign gpu_data = gpu_data_q;
    assign gpu_we   = gpu_we_q;
    assign done     = done_q;

    // Normalise corner order, then optionally clamp to the visible area.
    always_comb begin
        norm_xmin  = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
        norm_xmax  = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
        norm_ymin  = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
        norm_ymax  = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
        off_screen = 1'b0;
        if (CLIP_EN) begin
            // Checked on the unclamped minimum: a rectangle starting past the
            // edge has nothing visible to write.
            off_screen = (norm_xmin > X_LAST) || (norm_ymin > Y_LAST);
            if (norm_xmax > X_LAST) begin
                norm_xmax = X_LAST;
            end
            if (norm_ymax > Y_LAST) begin
                norm_ymax = Y_LAST;
            end
        end
    end

    // Next-state: latch the command on accept, then raster-step one pixel per cycle.
    always_comb begin
        state_d    = state_q;
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        ymax_d     = ymax_q;
        gpu_x_d    = gpu_x_q;
        gpu_y_d    = gpu_y_q;
        gpu_data_d = gpu_data_q;
        gpu_we_d   = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    xmin_d = norm_xmin;
                    xmax_d = norm_xmax;
                    ymax_d = norm_ymax;
                    if (off_screen) begin
                        // Nothing to draw: complete immediately, stay in IDLE.
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_FILL;
                        gpu_x_d    = norm_xmin;
                        gpu_y_d    = norm_ymin;
                        gpu_data_d = cmd_color;
                        gpu_we_d   = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                // Termination is on equality with the maxima, so the
                // counters never need to wrap.
                if (gpu_x_q < xmax_q) begin
                    gpu_x_d  = gpu_x_q + 10'd1;
                    gpu_we_d = 1'b1;
                end else if (gpu_y_q < ymax_q) begin
                    gpu_x_d  = xmin_q;
                    gpu_y_d  = gpu_y_q + 10'd1;
                    gpu_we_d = 1'b1;
                end else begin
                    // Write at (xmax,ymax) was the last; coordinates hold.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; async reset drops gpu_we and discards any command.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            xmin_q     <= 10'd0;
            xmax_q     <= 10'd0;
            ymax_q     <= 10'd0;
            gpu_x_q    <= 10'd0;
            gpu_y_q    <= 10'd0;
            gpu_data_q <= 4'd0;
            gpu_we_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            xmin_q     <= xmin_d;
            xmax_q     <= xmax_d;
            ymax_q     <= ymax_d;
            gpu_x_q    <= gpu_x_d;
            gpu_y_q    <= gpu_y_d;
            gpu_data_q <= gpu_data_d;
            gpu_we_q   <= gpu_we_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed cases plus randomized
// rectangles compared against a raster-order pixel list built from the rules.
module tb_rect_fill_engine;

    localparam int H_RES = 320;
    localparam int V_RES = 240;

    logic       Clk;
    logic       Reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [3:0] cmd_color;
    logic [9:0] gpu_x, gpu_y;
    logic [3:0] gpu_data;
    logic       gpu_we, busy, done;

    int checks;
    int failures;

    // Expected write list for the current command, in raster order.
    int exp_x[$];
    int exp_y[$];

    rect_fill_engine #(
        .H_RES(H_RES),
        .V_RES(V_RES)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_x0   (cmd_x0),
        .cmd_y0   (cmd_y0),
        .cmd_x1   (cmd_x1),
        .cmd_y1   (cmd_y1),
        .cmd_color(cmd_color),
        .gpu_x    (gpu_x),
        .gpu_y    (gpu_y),
        .gpu_data (gpu_data),
        .gpu_we   (gpu_we),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference: every pixel of the normalised (optionally clipped) rectangle.
    task automatic build_expected(input int x0, input int y0, input int x1, input int y1);
        int xa, xb, ya, yb;
        exp_x.delete();
        exp_y.delete();
        xa = (x0 < x1) ? x0 : x1;
        xb = (x0 < x1) ? x1 : x0;
        ya = (y0 < y1) ? y0 : y1;
        yb = (y0 < y1) ? y1 : y0;
`ifdef RECT_FILL_CLIP_EN
        if (xa >= H_RES || ya >= V_RES) return;
        if (xb > H_RES - 1) xb = H_RES - 1;
        if (yb > V_RES - 1) yb = V_RES - 1;
`endif
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                exp_x.push_back(x);
                exp_y.push_back(y);
            end
        end
    endtask

    // Presents a command in the current cycle and checks every cycle through done.
    // Returns in the done cycle with cmd_valid low, so a caller may issue the
    // next command back-to-back.
    task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                           input int color, input bit noise);
        int n;
        logic [3:0] c;
        c = color[3:0];
        build_expected(x0, y0, x1, y1);
        n = exp_x.size();
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_x0    = x0[9:0];
        cmd_y0    = y0[9:0];
        cmd_x1    = x1[9:0];
        cmd_y1    = y1[9:0];
        cmd_color = c;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("write_we", gpu_we, 1);
            chk("write_x", gpu_x, exp_x[i]);
            chk("write_y", gpu_y, exp_y[i]);
            chk("write_data", gpu_data, c);
            chk("fill_busy", busy, 1);
            chk("fill_ready", cmd_ready, 0);
            chk("fill_done", done, 0);
            // Garbage commands while filling must be ignored.
            if (noise && i < n - 1) begin
                cmd_valid = 1'b1;
                cmd_x0    = 10'($urandom);
                cmd_y0    = 10'($urandom);
                cmd_x1    = 10'($urandom);
                cmd_y1    = 10'($urandom);
                cmd_color = 4'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            step();
        end
        cmd_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_we", gpu_we, 0);
        chk("done_busy", busy, 0);
        chk("done_ready", cmd_ready, 1);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            step();
            chk("idle_we", gpu_we, 0);
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_ready", cmd_ready, 1);
        end
    endtask

    initial begin
        int x0, y0, x1, y1, col;
        checks    = 0;
        failures  = 0;
        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_x1    = '0;
        cmd_y1    = '0;
        cmd_color = '0;
        step();
        step();
        chk("rst_x", gpu_x, 0);
        chk("rst_y", gpu_y, 0);
        chk("rst_data", gpu_data, 0);
        chk("rst_we", gpu_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        Reset = 1'b0;
        idle_cycles(2);

        // 2x2 square, then the same with swapped corners.
        run_cmd(1, 1, 2, 2, 5, 1'b0);
        idle_cycles(1);
        run_cmd(2, 2, 1, 1, 5, 1'b1);
        idle_cycles(1);

        // Single pixel.
        run_cmd(7, 9, 7, 9, 15, 1'b0);
        idle_cycles(1);

        // Back-to-back: B presented in A's done cycle.
        run_cmd(0, 0, 1, 0, 3, 1'b0);
        run_cmd(4, 6, 5, 7, 10, 1'b0);
        idle_cycles(1);

        // Reset mid-fill of a 10x10 after 30 writes.
        build_expected(0, 0, 9, 9);
        cmd_valid = 1'b1;
        cmd_x0    = 10'd0;
        cmd_y0    = 10'd0;
        cmd_x1    = 10'd9;
        cmd_y1    = 10'd9;
        cmd_color = 4'd6;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            chk("pre_rst_x", gpu_x, exp_x[i]);
            chk("pre_rst_y", gpu_y, exp_y[i]);
            if (i < 29) step();
        end
        chk("pre_rst_we", gpu_we, 1);
        Reset = 1'b1;
        #1;
        chk("midrst_we", gpu_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_x", gpu_x, 0);
        step();
        Reset = 1'b0;
        idle_cycles(4);

        // Edge of the visible area.
`ifdef RECT_FILL_CLIP_EN
        run_cmd(318, 238, 400, 300, 9, 1'b0);
        idle_cycles(1);
        run_cmd(320, 0, 330, 5, 9, 1'b0);
        idle_cycles(1);
`else
        run_cmd(318, 0, 321, 0, 9, 1'b0);
        idle_cycles(1);
`endif

        // Randomized small rectangles, mixed gaps and corner order.
        for (int t = 0; t < 24; t++) begin
            if (t % 3 == 0) begin
                x0 = $urandom_range(300, 1015);
                y0 = $urandom_range(220, 1015);
            end else begin
                x0 = $urandom_range(0, 1015);
                y0 = $urandom_range(0, 1015);
            end
            x1  = x0 + $urandom_range(0, 7);
            y1  = y0 + $urandom_range(0, 5);
            col = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                run_cmd(x1, y1, x0, y0, col, ($urandom_range(0, 1) == 1));
            end else begin
                run_cmd(x0, y1, x1, y0, col, ($urandom_range(0, 1) == 1));
            end
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
